// File: rtl/serializer_pkg.sv
// Shared constants and helpers for the parallel serializer: default geometry,
// TMDS control/idle words and the bit-counter width function.
package serializer_pkg;

    localparam int DEFAULT_WIDTH    = 10;
    localparam int DEFAULT_CHANNELS = 4;

    localparam logic [9:0] TMDS_CTRL_00   = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01   = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10   = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11   = 10'b1010101011;
    localparam logic [9:0] TMDS_IDLE_WORD = TMDS_CTRL_00;

    typedef enum logic {
        LSB_FIRST_ORDER = 1'b0,
        MSB_FIRST_ORDER = 1'b1
    } bit_order_e;

    // Never narrower than one bit, so a single-slot counter still elaborates.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serializer_lane.sv
// One serializer lane: shift register plus registered output of STEP bits
// per enabled cycle, with the word reordered once at load time.
module serializer_lane
    import serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b0,
    parameter int STEP      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] word,
    output logic [STEP-1:0]  dout
);

    localparam bit_order_e ORDER = MSB_FIRST ? MSB_FIRST_ORDER : LSB_FIRST_ORDER;

    logic [WIDTH-1:0] ordered;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [STEP-1:0]  dout_q, dout_d;

    // ordered[k] is the k-th bit on the wire, so the shifter only moves right.
    always_comb begin
        ordered = word;
        if (ORDER == MSB_FIRST_ORDER) begin
            for (int i = 0; i < WIDTH; i++) begin
                ordered[i] = word[WIDTH-1-i];
            end
        end
    end

    always_comb begin
        sr_d   = sr_q;
        dout_d = dout_q;
        if (en && load) begin
            dout_d = ordered[STEP-1:0];
            sr_d   = ordered >> STEP;
        end else if (en && shift) begin
            dout_d = sr_q[STEP-1:0];
            sr_d   = sr_q >> STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            dout_q <= '0;
        end else begin
            sr_q   <= sr_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/parallel_serializer.sv
// Multi-lane parallel-to-serial converter with valid/ready load, idle-word
// underflow fill and word-boundary strobe. PARALLEL_SERIALIZER_DDR_EN selects two bits per cycle.
module parallel_serializer
    import serializer_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               CHANNELS  = DEFAULT_CHANNELS,
    parameter bit               MSB_FIRST = 1'b0,
    parameter logic [WIDTH-1:0] IDLE_WORD = TMDS_IDLE_WORD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      din_valid,
    output logic                      din_ready,
`ifdef PARALLEL_SERIALIZER_DDR_EN
    output logic [2*CHANNELS-1:0]     dout,
`else
    output logic [CHANNELS-1:0]       dout,
`endif
    output logic                      word_start,
    output logic                      underflow,
    input  logic                      clr_underflow
);

`ifdef PARALLEL_SERIALIZER_DDR_EN
    localparam int STEP = 2;
    if (WIDTH % 2 != 0) begin : g_odd_width
        $error("parallel_serializer: DDR mode needs an even WIDTH");
    end
`else
    localparam int STEP = 1;
`endif

    if (WIDTH < 2) begin : g_narrow_width
        $error("parallel_serializer: WIDTH must be at least 2");
    end

    localparam int             SLOTS = WIDTH / STEP;
    localparam int             CW    = cnt_width(SLOTS);
    localparam logic [CW-1:0]  LAST  = CW'(SLOTS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          word_start_q, word_start_d;
    logic          underflow_q, underflow_d;
    logic          load;
    logic          transfer;

    assign din_ready = en && (cnt_q == LAST);
    assign load      = din_ready;
    assign transfer  = load && din_valid;

    // A set in the load slot outranks a concurrent clear.
    always_comb begin
        cnt_d        = cnt_q;
        word_start_d = word_start_q;
        underflow_d  = underflow_q;
        if (en) begin
            cnt_d        = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            word_start_d = load;
        end
        if (load && !din_valid) begin
            underflow_d = 1'b1;
        end else if (clr_underflow) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= LAST;
            word_start_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            word_start_q <= word_start_d;
            underflow_q  <= underflow_d;
        end
    end

    assign word_start = word_start_q;
    assign underflow  = underflow_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [WIDTH-1:0] lane_word;
        assign lane_word = transfer ? din[c*WIDTH +: WIDTH] : IDLE_WORD;

        serializer_lane #(
            .WIDTH     (WIDTH),
            .MSB_FIRST (MSB_FIRST),
            .STEP      (STEP)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .load  (load),
            .shift (cnt_q != LAST),
            .word  (lane_word),
            .dout  (dout[c*STEP +: STEP])
        );
    end

endmodule

// File: tb/tb_parallel_serializer.sv
// Directed self-checking bench for parallel_serializer: an LSB-first and an
// MSB-first instance share stimulus; SDR or DDR follows PARALLEL_SERIALIZER_DDR_EN.
module tb_parallel_serializer;

    localparam int WIDTH = 10;
    localparam int CH    = 4;
`ifdef PARALLEL_SERIALIZER_DDR_EN
    localparam int STEP  = 2;
`else
    localparam int STEP  = 1;
`endif
    localparam int OW    = CH * STEP;
    localparam int SLOTS = WIDTH / STEP;

    localparam logic [9:0]          IDLE     = 10'b1101010100;
    localparam logic [CH*WIDTH-1:0] MIX      = {10'h155, 10'h3E0, 10'h3FF, 10'h2AA};
    localparam logic [CH*WIDTH-1:0] MSB_WORD = {4{10'h300}};
    localparam logic [CH*WIDTH-1:0] ONES     = {4{10'h3FF}};
    localparam logic [CH*WIDTH-1:0] IDLES    = {4{IDLE}};

    logic                clk = 1'b0;
    logic                rst, en, din_valid, clr_underflow;
    logic [CH*WIDTH-1:0] din, din_msb;
    logic                din_ready, word_start, underflow;
    logic                din_ready_m, word_start_m, underflow_m;
    logic [OW-1:0]       dout, dout_m;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    parallel_serializer #(.WIDTH(WIDTH), .CHANNELS(CH), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .word_start(word_start),
        .underflow(underflow), .clr_underflow(clr_underflow)
    );

    parallel_serializer #(.WIDTH(WIDTH), .CHANNELS(CH), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .en(en), .din(din_msb), .din_valid(din_valid),
        .din_ready(din_ready_m), .dout(dout_m), .word_start(word_start_m),
        .underflow(underflow_m), .clr_underflow(clr_underflow)
    );

    // Expected dout for slot k of a word: bit index k*STEP+s in wire order.
    function automatic logic [OW-1:0] expect_out(input logic [CH*WIDTH-1:0] d, input int k, input bit msb);
        logic [OW-1:0]    r;
        logic [WIDTH-1:0] w;
        int               idx;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            w = d[c*WIDTH +: WIDTH];
            for (int s = 0; s < STEP; s++) begin
                idx = k*STEP + s;
                if (msb) idx = WIDTH-1-idx;
                r[c*STEP+s] = w[idx];
            end
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go_to_load;
        int n;
        n = 0;
        while (din_ready !== 1'b1 && n < 2*WIDTH) begin
            tick;
            n++;
        end
        checks++;
        if (din_ready !== 1'b1) $display("[TB] FAIL go_to_load din_ready got %b want 1", din_ready);
        else passes++;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; din_valid = 1'b0; clr_underflow = 1'b0;
        din = '0; din_msb = '0;
        repeat (3) tick;
        checks++; if (dout !== '0) $display("[TB] FAIL reset_dout got %h want 0", dout); else passes++;
        checks++; if (word_start !== 1'b0) $display("[TB] FAIL reset_word_start got %b want 0", word_start); else passes++;
        checks++; if (underflow !== 1'b0) $display("[TB] FAIL reset_underflow got %b want 0", underflow); else passes++;
        checks++; if (din_ready !== 1'b0) $display("[TB] FAIL reset_ready_en_low got %b want 0", din_ready); else passes++;
        en = 1'b1;
        tick;
        checks++; if (din_ready !== 1'b1) $display("[TB] FAIL reset_ready_en_high got %b want 1", din_ready); else passes++;
    endtask

    task automatic test_stream;
        int kk;
        din = MIX; din_msb = MSB_WORD; din_valid = 1'b1; rst = 1'b0;
        tick;
        for (int k = 0; k < 2*SLOTS; k++) begin
            if (k > 0) tick;
            kk = k % SLOTS;
            checks++;
            if (dout !== expect_out(MIX, kk, 1'b0))
                $display("[TB] FAIL stream_dout k=%0d got %h want %h", k, dout, expect_out(MIX, kk, 1'b0));
            else passes++;
            checks++;
            if (dout_m !== expect_out(MSB_WORD, kk, 1'b1))
                $display("[TB] FAIL stream_msb_dout k=%0d got %h want %h", k, dout_m, expect_out(MSB_WORD, kk, 1'b1));
            else passes++;
            checks++;
            if (word_start !== (kk == 0))
                $display("[TB] FAIL stream_word_start k=%0d got %b want %b", k, word_start, (kk == 0));
            else passes++;
            checks++;
            if (din_ready !== (kk == SLOTS-1))
                $display("[TB] FAIL stream_ready k=%0d got %b want %b", k, din_ready, (kk == SLOTS-1));
            else passes++;
        end
        checks++; if (underflow !== 1'b0) $display("[TB] FAIL stream_underflow got %b want 0", underflow); else passes++;
    endtask

    task automatic test_underflow;
        din_valid = 1'b0;
        tick;
        din_valid = 1'b1;
        for (int k = 0; k < SLOTS; k++) begin
            if (k > 0) tick;
            checks++;
            if (dout !== expect_out(IDLES, k, 1'b0))
                $display("[TB] FAIL idle_dout k=%0d got %h want %h", k, dout, expect_out(IDLES, k, 1'b0));
            else passes++;
            checks++;
            if (dout_m !== expect_out(IDLES, k, 1'b1))
                $display("[TB] FAIL idle_msb_dout k=%0d got %h want %h", k, dout_m, expect_out(IDLES, k, 1'b1));
            else passes++;
            checks++;
            if (underflow !== 1'b1) $display("[TB] FAIL idle_underflow k=%0d got %b want 1", k, underflow);
            else passes++;
        end
        tick;
        checks++; if (underflow !== 1'b1) $display("[TB] FAIL underflow_sticky got %b want 1", underflow); else passes++;
        checks++; if (word_start !== 1'b1) $display("[TB] FAIL underflow_reload_ws got %b want 1", word_start); else passes++;
        clr_underflow = 1'b1;
        #1;
        checks++; if (underflow !== 1'b1) $display("[TB] FAIL clear_before_edge got %b want 1", underflow); else passes++;
        tick;
        clr_underflow = 1'b0;
        checks++; if (underflow !== 1'b0) $display("[TB] FAIL clear_after_edge got %b want 0", underflow); else passes++;
        go_to_load;
        din_valid = 1'b0; clr_underflow = 1'b1;
        tick;
        din_valid = 1'b1; clr_underflow = 1'b0;
        checks++; if (underflow !== 1'b1) $display("[TB] FAIL set_wins_over_clear got %b want 1", underflow); else passes++;
    endtask

    task automatic test_enable;
        clr_underflow = 1'b1;
        tick;
        clr_underflow = 1'b0;
        go_to_load;
        din = MIX;
        tick;
        for (int k = 0; k < SLOTS; k++) begin
            if (k > 0) tick;
            checks++;
            if (dout !== expect_out(MIX, k, 1'b0))
                $display("[TB] FAIL enable_dout k=%0d got %h want %h", k, dout, expect_out(MIX, k, 1'b0));
            else passes++;
            if (k == 2) begin
                en = 1'b0;
                repeat (2) tick;
                checks++;
                if (dout !== expect_out(MIX, k, 1'b0))
                    $display("[TB] FAIL enable_hold_dout got %h want %h", dout, expect_out(MIX, k, 1'b0));
                else passes++;
                checks++; if (word_start !== 1'b0) $display("[TB] FAIL enable_hold_ws got %b want 0", word_start); else passes++;
                checks++; if (din_ready !== 1'b0) $display("[TB] FAIL enable_hold_ready got %b want 0", din_ready); else passes++;
                en = 1'b1;
            end
        end
        en = 1'b0; din_valid = 1'b0;
        #1;
        checks++; if (din_ready !== 1'b0) $display("[TB] FAIL enable_low_load_ready got %b want 0", din_ready); else passes++;
        tick;
        checks++; if (underflow !== 1'b0) $display("[TB] FAIL enable_low_underflow got %b want 0", underflow); else passes++;
        checks++; if (word_start !== 1'b0) $display("[TB] FAIL enable_low_ws got %b want 0", word_start); else passes++;
        en = 1'b1; din_valid = 1'b1;
        #1;
        checks++; if (din_ready !== 1'b1) $display("[TB] FAIL enable_resume_ready got %b want 1", din_ready); else passes++;
        tick;
        checks++; if (word_start !== 1'b1) $display("[TB] FAIL enable_resume_ws got %b want 1", word_start); else passes++;
    endtask

    task automatic test_reset_mid;
        go_to_load;
        din_valid = 1'b0;
        tick;
        din_valid = 1'b1; din = ONES;
        go_to_load;
        tick;
        repeat (SLOTS/2) tick;
        checks++; if (dout !== {OW{1'b1}}) $display("[TB] FAIL midword_dout got %h want all ones", dout); else passes++;
        checks++; if (underflow !== 1'b1) $display("[TB] FAIL midword_underflow got %b want 1", underflow); else passes++;
        rst = 1'b1;
        tick;
        checks++; if (dout !== '0) $display("[TB] FAIL midreset_dout got %h want 0", dout); else passes++;
        checks++; if (word_start !== 1'b0) $display("[TB] FAIL midreset_ws got %b want 0", word_start); else passes++;
        checks++; if (underflow !== 1'b0) $display("[TB] FAIL midreset_underflow got %b want 0", underflow); else passes++;
        checks++; if (din_ready !== 1'b1) $display("[TB] FAIL midreset_ready got %b want 1", din_ready); else passes++;
        rst = 1'b0; din = MIX;
        tick;
        checks++; if (word_start !== 1'b1) $display("[TB] FAIL release_ws got %b want 1", word_start); else passes++;
        checks++;
        if (dout !== expect_out(MIX, 0, 1'b0))
            $display("[TB] FAIL release_dout0 got %h want %h", dout, expect_out(MIX, 0, 1'b0));
        else passes++;
        tick;
        checks++;
        if (dout !== expect_out(MIX, 1, 1'b0))
            $display("[TB] FAIL release_dout1 got %h want %h", dout, expect_out(MIX, 1, 1'b0));
        else passes++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset;
        test_stream;
        test_underflow;
        test_enable;
        test_reset_mid;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
